// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low, bit6=g ... bit0=a) and scan-decoder FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_ERR   = 4'hE;

    typedef enum logic [1:0] {StWait, StSettle, StHold} scan_state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display-bus tap and decoded-frame signals; SEG7_DP_EN adds the decimal-point lines.
interface seg7_scan_decoder_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_valid;
`ifdef SEG7_DP_EN
    logic                    seg_dp_n;
    logic [NUM_DIGITS-1:0]   dp;

    modport master (output seg_n, an_n, seg_dp_n, input digits, digit_err, frame_valid, dp);
    modport slave  (input seg_n, an_n, seg_dp_n, output digits, digit_err, frame_valid, dp);
`else
    modport master (output seg_n, an_n, input digits, digit_err, frame_valid);
    modport slave  (input seg_n, an_n, output digits, digit_err, frame_valid);
`endif
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low 7-segment pattern to 4-bit value; unknown patterns flag an error.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg_n,
    output logic [3:0] o_value,
    output logic       o_err
);

    always_comb begin
        o_value = DIG_ERR;
        o_err   = 1'b1;
        case (i_seg_n)
            SEG_0:     begin o_value = 4'd0;      o_err = 1'b0; end
            SEG_1:     begin o_value = 4'd1;      o_err = 1'b0; end
            SEG_2:     begin o_value = 4'd2;      o_err = 1'b0; end
            SEG_3:     begin o_value = 4'd3;      o_err = 1'b0; end
            SEG_4:     begin o_value = 4'd4;      o_err = 1'b0; end
            SEG_5:     begin o_value = 4'd5;      o_err = 1'b0; end
            SEG_6:     begin o_value = 4'd6;      o_err = 1'b0; end
            SEG_7:     begin o_value = 4'd7;      o_err = 1'b0; end
            SEG_8:     begin o_value = 4'd8;      o_err = 1'b0; end
            SEG_9:     begin o_value = 4'd9;      o_err = 1'b0; end
            SEG_BLANK: begin o_value = DIG_BLANK; o_err = 1'b0; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment bus receiver: sync, stability filter, per-strobe capture, frame publish.
// Optional SEG7_DP_EN also captures the decimal point per digit.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input logic              clk,
    input logic              rst,
    seg7_scan_decoder_if.slave bus
);

    localparam int unsigned      CntW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0]  CntMax = CntW'(STABLE_CYCLES);

    logic [6:0]              r_seg_meta, r_seg_sync, r_seg_prev;
    logic [NUM_DIGITS-1:0]   r_an_meta, r_an_sync, r_an_prev;
    logic [CntW-1:0]         r_cnt;
    scan_state_e             r_state, w_state_d;
    logic                    w_changed, w_dp_changed, w_onehot, w_capture;
    logic [3:0]              w_dec_value;
    logic                    w_dec_err;
    logic [NUM_DIGITS-1:0]   r_seen, w_seen_d;
    logic                    r_pend, r_valid;
    logic [4*NUM_DIGITS-1:0] r_shadow_val, r_digits;
    logic [NUM_DIGITS-1:0]   r_shadow_err, r_digit_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_meta <= SEG_BLANK;
            r_seg_sync <= SEG_BLANK;
            r_seg_prev <= SEG_BLANK;
            r_an_meta  <= '1;
            r_an_sync  <= '1;
            r_an_prev  <= '1;
            r_cnt      <= '0;
        end else begin
            r_seg_meta <= bus.seg_n;
            r_seg_sync <= r_seg_meta;
            r_seg_prev <= r_seg_sync;
            r_an_meta  <= bus.an_n;
            r_an_sync  <= r_an_meta;
            r_an_prev  <= r_an_sync;
            if (w_changed) begin
                r_cnt <= CntW'(1);
            end else if (r_cnt != CntMax) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef SEG7_DP_EN
    logic                  r_dp_meta, r_dp_sync, r_dp_prev;
    logic [NUM_DIGITS-1:0] r_shadow_dp, r_dp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_meta   <= 1'b1;
            r_dp_sync   <= 1'b1;
            r_dp_prev   <= 1'b1;
            r_shadow_dp <= '0;
            r_dp        <= '0;
        end else begin
            r_dp_meta <= bus.seg_dp_n;
            r_dp_sync <= r_dp_meta;
            r_dp_prev <= r_dp_sync;
            if (r_pend) begin
                r_dp <= r_shadow_dp;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_capture && !r_an_sync[i]) begin
                    r_shadow_dp[i] <= ~r_dp_sync;
                end
            end
        end
    end

    assign w_dp_changed = (r_dp_sync != r_dp_prev);
    assign bus.dp       = r_dp;
`else
    assign w_dp_changed = 1'b0;
`endif

    assign w_changed = (r_seg_sync != r_seg_prev) || (r_an_sync != r_an_prev) || w_dp_changed;
    assign w_onehot  = $onehot(~r_an_sync);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StWait;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_capture = 1'b0;
        unique case (r_state)
            StWait: begin
                if (w_onehot) begin
                    w_state_d = StSettle;
                end
            end
            StSettle: begin
                if (!w_onehot) begin
                    w_state_d = StWait;
                end else if (!w_changed && r_cnt == CntMax) begin
                    w_capture = 1'b1;
                    w_state_d = StHold;
                end
            end
            StHold: begin
                if (w_changed) begin
                    w_state_d = w_onehot ? StSettle : StWait;
                end
            end
            default: w_state_d = StWait;
        endcase
    end

    seg7_pattern_decode u_decode (
        .i_seg_n (r_seg_sync),
        .o_value (w_dec_value),
        .o_err   (w_dec_err)
    );

    // A capture in the publish cycle lands in the freshly cleared mask.
    assign w_seen_d = (r_pend ? '0 : r_seen) | (w_capture ? ~r_an_sync : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen       <= '0;
            r_pend       <= 1'b0;
            r_valid      <= 1'b0;
            r_shadow_val <= '0;
            r_shadow_err <= '0;
            r_digits     <= '0;
            r_digit_err  <= '0;
        end else begin
            r_seen  <= w_seen_d;
            r_pend  <= w_capture && (&w_seen_d);
            r_valid <= r_pend;
            if (r_pend) begin
                r_digits    <= r_shadow_val;
                r_digit_err <= r_shadow_err;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_capture && !r_an_sync[i]) begin
                    r_shadow_val[4*i +: 4] <= w_dec_value;
                    r_shadow_err[i]        <= w_dec_err;
                end
            end
        end
    end

    assign bus.digits      = r_digits;
    assign bus.digit_err   = r_digit_err;
    assign bus.frame_valid = r_valid;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=8); SEG7_DP_EN adds dp checks.
module tb_seg7_scan_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [6:0] P0   = 7'b1000000;
    localparam logic [6:0] P1   = 7'b1111001;
    localparam logic [6:0] P2   = 7'b0100100;
    localparam logic [6:0] P3   = 7'b0110000;
    localparam logic [6:0] P4   = 7'b0011001;
    localparam logic [6:0] P5   = 7'b0010010;
    localparam logic [6:0] P6   = 7'b0000010;
    localparam logic [6:0] P7   = 7'b1111000;
    localparam logic [6:0] P8   = 7'b0000000;
    localparam logic [6:0] P9   = 7'b0010000;
    localparam logic [6:0] PB   = 7'b1111111;
    localparam logic [6:0] PBAD = 7'b0000001;

    int checks   = 0;
    int errors   = 0;
    int fv_count = 0;
    int lat;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_count <= fv_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        bus.an_n  = an;
        bus.seg_n = seg;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
`ifdef SEG7_DP_EN
        bus.seg_dp_n = 1'b1;
`endif
        drive(4'b1111, PB, 4);
        check("rst_digits", 32'(bus.digits), 32'h0);
        check("rst_err", 32'(bus.digit_err), 32'h0);
        check("rst_fv", 32'(bus.frame_valid), 32'h0);
        rst = 1'b0;
        drive(4'b1111, PB, 5);

        // 1: basic frame, last digit timed from pin change to frame_valid
        fv_count = 0;
        drive(4'b1110, P1, 20);
        drive(4'b1101, P2, 20);
        drive(4'b1011, P3, 20);
        bus.an_n  = 4'b0111;
        bus.seg_n = P4;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (lat == 0 && bus.frame_valid === 1'b1) lat = i;
        end
        check("t1_latency", 32'(lat), 32'd12);
        drive(4'b1111, PB, 10);
        check("t1_fv_count", 32'(fv_count), 32'd1);
        check("t1_digits", 32'(bus.digits), 32'h4321);
        check("t1_err", 32'(bus.digit_err), 32'h0);

        // 2: digit 0 too short to capture, so the other three cannot finish a frame
        fv_count = 0;
        drive(4'b1110, P0, 5);
        drive(4'b1111, PB, 20);
        drive(4'b1101, P5, 20);
        drive(4'b1011, P6, 20);
        drive(4'b0111, P7, 20);
        drive(4'b1111, PB, 20);
        check("t2_no_frame", 32'(fv_count), 32'd0);
        check("t2_digits_hold", 32'(bus.digits), 32'h4321);
        drive(4'b1110, P8, 20);
        drive(4'b1111, PB, 10);
        check("t2_fv_count", 32'(fv_count), 32'd1);
        check("t2_digits", 32'(bus.digits), 32'h7658);

        // 3: unrecognised pattern on digit 2
        fv_count = 0;
        drive(4'b1110, P9, 20);
        drive(4'b1101, P0, 20);
        drive(4'b1011, PBAD, 20);
        drive(4'b0111, P3, 20);
        drive(4'b1111, PB, 10);
        check("t3_fv_count", 32'(fv_count), 32'd1);
        check("t3_digits", 32'(bus.digits), 32'h3E09);
        check("t3_err", 32'(bus.digit_err), 32'h4);

        // 4: two strobes low at once must be ignored
        fv_count = 0;
        drive(4'b1110, P1, 20);
        drive(4'b1101, P2, 20);
        drive(4'b1100, P3, 30);
        drive(4'b1011, P3, 20);
        check("t4_no_early_frame", 32'(fv_count), 32'd0);
        drive(4'b0111, P4, 20);
        drive(4'b1111, PB, 10);
        check("t4_fv_count", 32'(fv_count), 32'd1);
        check("t4_digits", 32'(bus.digits), 32'h4321);
        check("t4_err", 32'(bus.digit_err), 32'h0);

        // 5: reset mid-frame discards captured digits 0 and 1
        fv_count = 0;
        drive(4'b1110, P5, 20);
        drive(4'b1101, P6, 20);
        drive(4'b1111, PB, 5);
        rst = 1'b1;
        drive(4'b1111, PB, 3);
        check("t5_rst_digits", 32'(bus.digits), 32'h0);
        check("t5_rst_err", 32'(bus.digit_err), 32'h0);
        rst = 1'b0;
        drive(4'b1011, P7, 20);
        drive(4'b0111, P8, 20);
        drive(4'b1111, PB, 20);
        check("t5_partial_no_frame", 32'(fv_count), 32'd0);
        drive(4'b1110, P1, 20);
        drive(4'b1101, P2, 20);
        drive(4'b1111, PB, 10);
        check("t5_fv_count", 32'(fv_count), 32'd1);
        check("t5_digits", 32'(bus.digits), 32'h8721);

        // 6: blank frame, decimal point on digit 3
        fv_count = 0;
        drive(4'b1110, PB, 20);
        drive(4'b1101, PB, 20);
        drive(4'b1011, PB, 20);
`ifdef SEG7_DP_EN
        bus.seg_dp_n = 1'b0;
`endif
        drive(4'b0111, PB, 20);
`ifdef SEG7_DP_EN
        bus.seg_dp_n = 1'b1;
`endif
        drive(4'b1111, PB, 10);
        check("t6_fv_count", 32'(fv_count), 32'd1);
        check("t6_digits", 32'(bus.digits), 32'hFFFF);
        check("t6_err", 32'(bus.digit_err), 32'h0);
`ifdef SEG7_DP_EN
        check("t6_dp", 32'(bus.dp), 32'h8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
